// File: rtl/axi_arb_pkg.sv
// Shared arbitration encodings and sizing helpers for the AW arbiter.
// Pure definitions; no logic, no latency.
package axi_arb_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Grant index width, never narrower than one bit.
  function automatic int calc_id_w(input int num_ch);
    int w;
    w = $clog2(num_ch);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel selector: round-robin from ptr_i, or fixed lowest-index priority.
// Zero latency; only requesting channels are ever granted.
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [ID_W-1:0]   ptr_i,
  input  logic              mode_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [ID_W-1:0]   grant_idx_o,
  output logic              any_grant_o
);

  always_comb begin
    int base;
    int idx;
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    // Fixed mode and an out-of-range pointer both scan from channel 0.
    base = (mode_i || (int'(ptr_i) >= NUM_CH)) ? 0 : int'(ptr_i);
    for (int k = 0; k < NUM_CH; k++) begin
      idx = base + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_grant_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = ID_W'(idx);
        any_grant_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_aw_arbiter.sv
// N:1 AXI write-address arbiter with a single registered output slot.
// Latency 1; refills on the same cycle it drains, so s_awready stalls only while m_awready is low.
module axi_aw_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*ADDR_W-1:0]   s_awaddr,
  input  logic [NUM_CH-1:0]          s_awvalid,
  output logic [NUM_CH-1:0]          s_awready,
  output logic [ADDR_W-1:0]          m_awaddr,
  output logic [calc_id_w(NUM_CH)-1:0] m_awid,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic                       busy
);

  localparam int ID_W = calc_id_w(NUM_CH);
  localparam logic [ID_W-1:0] LAST_CH = ID_W'(NUM_CH - 1);
  localparam logic FIXED_MODE = (ARB_MODE == ARB_FIXED);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              vld_q, vld_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic              load;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [ID_W-1:0]   grant_idx;
  logic              any_grant;
  logic [ADDR_W-1:0] sel_addr;

  // Requests are masked while held in reset so s_awready stays low.
  assign load = !vld_q || m_awready;
  assign req  = (load && !rst) ? s_awvalid : '0;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_arb (
    .req_i       (req),
    .ptr_i       (rr_ptr_q),
    .mode_i      (FIXED_MODE),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) sel_addr = sel_addr | s_awaddr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    addr_d   = addr_q;
    id_d     = id_q;
    vld_d    = vld_q;
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      addr_d = sel_addr;
      id_d   = grant_idx;
      vld_d  = 1'b1;
      if (!FIXED_MODE) rr_ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
    end else if (m_awready) begin
      vld_d = 1'b0;
    end
    if (FIXED_MODE) rr_ptr_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      id_q     <= '0;
      vld_q    <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      addr_q   <= addr_d;
      id_q     <= id_d;
      vld_q    <= vld_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign s_awready = grant;
  assign m_awaddr  = addr_q;
  assign m_awid    = id_q;
  assign m_awvalid = vld_q;
  assign busy      = vld_q || (|s_awvalid);

endmodule

// File: tb/tb_axi_aw_arbiter.sv
// Directed bench for axi_aw_arbiter: round-robin instance plus a fixed-priority instance.
module tb_axi_aw_arbiter;

  localparam logic [31:0] A0 = 32'h0000_0A00;
  localparam logic [31:0] A1 = 32'h0000_0B00;
  localparam logic [31:0] A2 = 32'h0000_1000;
  localparam logic [31:0] A3 = 32'h0000_2C00;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic [127:0] s_awaddr;
  logic [3:0]   s_awvalid = '0;
  logic [3:0]   s_awready;
  logic [31:0]  m_awaddr;
  logic [1:0]   m_awid;
  logic         m_awvalid;
  logic         m_awready = 1'b0;
  logic         busy;

  logic [3:0]   fx_awvalid = '0;
  logic [3:0]   fx_awready;
  logic [31:0]  fx_m_awaddr;
  logic [1:0]   fx_m_awid;
  logic         fx_m_awvalid;
  logic         fx_m_awready = 1'b0;
  logic         fx_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  initial s_awaddr = {A3, A2, A1, A0};

  axi_aw_arbiter #(.NUM_CH(4), .ADDR_W(32), .ARB_MODE(0)) dut (
    .clk(clk), .rst(rst), .s_awaddr(s_awaddr), .s_awvalid(s_awvalid),
    .s_awready(s_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .busy(busy)
  );

  axi_aw_arbiter #(.NUM_CH(4), .ADDR_W(32), .ARB_MODE(1)) dut_fx (
    .clk(clk), .rst(rst), .s_awaddr(s_awaddr), .s_awvalid(fx_awvalid),
    .s_awready(fx_awready), .m_awaddr(fx_m_awaddr), .m_awid(fx_m_awid),
    .m_awvalid(fx_m_awvalid), .m_awready(fx_m_awready), .busy(fx_busy)
  );

  function automatic logic [31:0] ch_addr(input int i);
    case (i)
      0: return A0;
      1: return A1;
      2: return A2;
      default: return A3;
    endcase
  endfunction

  task automatic test_reset();
    #2;
    checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", m_awvalid); end
    checks++; if (m_awaddr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", m_awaddr); end
    checks++; if (m_awid !== 2'd0) begin errors++; $display("FAIL rst_id got %0d exp 0", m_awid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_idle got %b exp 0", busy); end
    s_awvalid = 4'hF;
    #1;
    checks++; if (s_awready !== 4'b0000) begin errors++; $display("FAIL rst_rdy got %b exp 0000", s_awready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_req got %b exp 1", busy); end
    checks++; if (dut.rr_ptr_q !== 2'd0) begin errors++; $display("FAIL rst_ptr got %0d exp 0", dut.rr_ptr_q); end
    @(posedge clk); #1;
    rst = 1'b0;
    s_awvalid = 4'h0;
  endtask

  task automatic test_rr_stream();
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
    s_awvalid = 4'hF;
    m_awready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_rdy = 4'b0001 << (c % 4);
      checks++; if (s_awready !== exp_rdy) begin errors++; $display("FAIL rr_rdy c%0d got %b exp %b", c, s_awready, exp_rdy); end
      if (c > 0) begin
        exp_id = 2'((c - 1) % 4);
        checks++; if (m_awvalid !== 1'b1) begin errors++; $display("FAIL rr_vld c%0d got %b exp 1", c, m_awvalid); end
        checks++; if (m_awid !== exp_id) begin errors++; $display("FAIL rr_id c%0d got %0d exp %0d", c, m_awid, exp_id); end
        checks++; if (m_awaddr !== ch_addr(int'(exp_id))) begin errors++; $display("FAIL rr_addr c%0d got %h exp %h", c, m_awaddr, ch_addr(int'(exp_id))); end
      end
      @(posedge clk); #1;
    end
    s_awvalid = 4'h0;
    @(negedge clk);
    checks++; if (m_awid !== 2'd1 || m_awvalid !== 1'b1) begin errors++; $display("FAIL rr_last got id%0d v%b exp id1 v1", m_awid, m_awvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy c%0d got %b exp 0", c, busy); end
      checks++; if (s_awready !== 4'b0) begin errors++; $display("FAIL idle_rdy c%0d got %b exp 0000", c, s_awready); end
      checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL idle_vld c%0d got %b exp 0", c, m_awvalid); end
      checks++; if (dut.rr_ptr_q !== 2'd2) begin errors++; $display("FAIL idle_ptr c%0d got %0d exp 2", c, dut.rr_ptr_q); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    s_awvalid = 4'b0100;
    m_awready = 1'b0;
    @(negedge clk);
    checks++; if (s_awready !== 4'b0100) begin errors++; $display("FAIL bp_accept got %b exp 0100", s_awready); end
    @(posedge clk); #1;
    s_awvalid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (m_awvalid !== 1'b1) begin errors++; $display("FAIL bp_vld c%0d got %b exp 1", c, m_awvalid); end
      checks++; if (m_awaddr !== 32'h0000_1000) begin errors++; $display("FAIL bp_addr c%0d got %h exp 00001000", c, m_awaddr); end
      checks++; if (m_awid !== 2'd2) begin errors++; $display("FAIL bp_id c%0d got %0d exp 2", c, m_awid); end
      checks++; if (s_awready !== 4'b0000) begin errors++; $display("FAIL bp_rdy c%0d got %b exp 0000", c, s_awready); end
      @(posedge clk); #1;
    end
    m_awready = 1'b1;
    @(negedge clk);
    checks++; if (s_awready !== 4'b1000) begin errors++; $display("FAIL bp_release_rdy got %b exp 1000", s_awready); end
    checks++; if (m_awid !== 2'd2) begin errors++; $display("FAIL bp_release_id got %0d exp 2", m_awid); end
    @(posedge clk); #1;
    s_awvalid = 4'h0;
    @(negedge clk);
    checks++; if (m_awvalid !== 1'b1 || m_awid !== 2'd3) begin errors++; $display("FAIL bp_next got v%b id%0d exp v1 id3", m_awvalid, m_awid); end
    checks++; if (m_awaddr !== A3) begin errors++; $display("FAIL bp_next_addr got %h exp %h", m_awaddr, A3); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", m_awvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    s_awvalid = 4'b0100;
    m_awready = 1'b1;
    @(negedge clk);
    checks++; if (s_awready !== 4'b0100) begin errors++; $display("FAIL wrap_ch2 got %b exp 0100", s_awready); end
    @(posedge clk); #1;
    s_awvalid = 4'b1001;
    @(negedge clk);
    checks++; if (dut.rr_ptr_q !== 2'd3) begin errors++; $display("FAIL wrap_ptr got %0d exp 3", dut.rr_ptr_q); end
    checks++; if (s_awready !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b exp 1000", s_awready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (s_awready !== 4'b0001) begin errors++; $display("FAIL wrap_second got %b exp 0001", s_awready); end
    checks++; if (m_awid !== 2'd3) begin errors++; $display("FAIL wrap_id3 got %0d exp 3", m_awid); end
    @(posedge clk); #1;
    s_awvalid = 4'h0;
    @(negedge clk);
    checks++; if (m_awid !== 2'd0 || m_awaddr !== A0) begin errors++; $display("FAIL wrap_id0 got id%0d addr %h exp id0 addr %h", m_awid, m_awaddr, A0); end
    @(posedge clk); #1;
  endtask

  task automatic test_fixed();
    fx_awvalid   = 4'b1010;
    fx_m_awready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (fx_awready !== 4'b0010) begin errors++; $display("FAIL fx_rdy c%0d got %b exp 0010", c, fx_awready); end
      checks++; if (dut_fx.rr_ptr_q !== 2'd0) begin errors++; $display("FAIL fx_ptr c%0d got %0d exp 0", c, dut_fx.rr_ptr_q); end
      if (c > 0) begin
        checks++; if (fx_m_awid !== 2'd1 || fx_m_awvalid !== 1'b1) begin errors++; $display("FAIL fx_id c%0d got id%0d v%b exp id1 v1", c, fx_m_awid, fx_m_awvalid); end
      end
      @(posedge clk); #1;
    end
    fx_awvalid = 4'b1000;
    @(negedge clk);
    checks++; if (fx_awready !== 4'b1000) begin errors++; $display("FAIL fx_ch3 got %b exp 1000", fx_awready); end
    @(posedge clk); #1;
    fx_awvalid = 4'b0000;
    @(negedge clk);
    checks++; if (fx_m_awid !== 2'd3 || fx_m_awaddr !== A3) begin errors++; $display("FAIL fx_out3 got id%0d addr %h exp id3 addr %h", fx_m_awid, fx_m_awaddr, A3); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    s_awvalid = 4'b0010;
    m_awready = 1'b0;
    @(negedge clk);
    checks++; if (s_awready !== 4'b0010) begin errors++; $display("FAIL rm_accept got %b exp 0010", s_awready); end
    @(posedge clk); #1;
    s_awvalid = 4'h0;
    checks++; if (m_awvalid !== 1'b1 || m_awid !== 2'd1) begin errors++; $display("FAIL rm_held got v%b id%0d exp v1 id1", m_awvalid, m_awid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL rm_vld got %b exp 0", m_awvalid); end
    checks++; if (m_awaddr !== 32'h0 || m_awid !== 2'd0) begin errors++; $display("FAIL rm_clear got addr %h id%0d exp 0", m_awaddr, m_awid); end
    checks++; if (dut.rr_ptr_q !== 2'd0) begin errors++; $display("FAIL rm_ptr got %0d exp 0", dut.rr_ptr_q); end
    s_awvalid = 4'hF;
    #1;
    checks++; if (s_awready !== 4'b0000) begin errors++; $display("FAIL rm_rdy got %b exp 0000", s_awready); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_awready = 1'b1;
    @(negedge clk);
    checks++; if (s_awready !== 4'b0001) begin errors++; $display("FAIL rm_first_rdy got %b exp 0001", s_awready); end
    @(posedge clk); #1;
    s_awvalid = 4'h0;
    @(negedge clk);
    checks++; if (m_awvalid !== 1'b1 || m_awid !== 2'd0) begin errors++; $display("FAIL rm_first_id got v%b id%0d exp v1 id0", m_awvalid, m_awid); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_rr_stream();
    test_idle();
    test_backpressure();
    test_wrap();
    test_fixed();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_aw_arbiter.md
AXI_AW_ARBITER -- requirements
Module: axi_aw_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of upstream AW channels (legal 2..16).
REQ-002 Parameter ADDR_W, default 32, SHALL set the AW address width (legal 12..64).
REQ-003 Parameter ARB_MODE, default 0, SHALL select arbitration: 0 round-robin, 1 fixed priority (lowest index wins).
REQ-004 Local constant ID_W = max(1, clog2(NUM_CH)) SHALL size the grant index.
REQ-005 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 s_awaddr  input  NUM_CH*ADDR_W  packed upstream addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 s_awvalid  input  NUM_CH  per-channel request valid.
REQ-009 s_awready  output  NUM_CH  per-channel accept; at most one bit high per cycle.
REQ-010 m_awaddr  output  ADDR_W  registered downstream address.
REQ-011 m_awid  output  ID_W  index of the source channel of the current downstream beat.
REQ-012 m_awvalid  output  1  downstream valid.
REQ-013 m_awready  input  1  downstream ready.
REQ-014 busy  output  1  high while m_awvalid is high or any s_awvalid bit is high.

Function
REQ-015 One output holding register (addr, id, valid) SHALL exist; "load" = !m_awvalid || m_awready.
REQ-016 When load is high and any s_awvalid bit is set, the arbiter SHALL grant exactly one channel and assert only that channel's s_awready in the same cycle (combinational).
REQ-017 When load is low, all s_awready bits SHALL be 0.
REQ-018 An upstream handshake (s_awvalid[i] && s_awready[i]) SHALL produce m_awvalid=1, m_awaddr=s_awaddr[i], m_awid=i on the next cycle (latency 1).
REQ-019 A downstream handshake with no new grant SHALL clear m_awvalid on the next cycle; a downstream handshake with a simultaneous grant SHALL replace the register contents without a bubble (full throughput, 1 beat/cycle).
REQ-020 While m_awvalid=1 and m_awready=0, m_awaddr, m_awid and m_awvalid SHALL stay stable.
REQ-021 Round-robin: a priority pointer rr_ptr (ID_W bits) SHALL select the first requesting channel at or after rr_ptr, wrapping from NUM_CH-1 to 0.
REQ-022 Round-robin: after each accepted upstream handshake on channel g, rr_ptr SHALL become g+1, wrapping to 0 when g=NUM_CH-1; otherwise rr_ptr SHALL hold.
REQ-023 Fixed priority: the lowest-index requesting channel SHALL win; rr_ptr SHALL be held at 0.
REQ-024 Grant SHALL never be given to a channel whose s_awvalid is 0; no requests -> no grant, no state change except REQ-019.
REQ-025 No starvation in mode 0: a channel that holds s_awvalid high SHALL be granted within NUM_CH accepted handshakes.
REQ-026 Sampling rule: an upstream channel that drops s_awvalid before a handshake SHALL simply not be granted; the block SHALL not store it.

Reset
REQ-027 During rst: m_awvalid=0, m_awaddr=0, m_awid=0, rr_ptr=0, s_awready=0, busy reflects s_awvalid only.
REQ-028 rst asserted mid-transfer SHALL discard the held beat immediately (asynchronously); the first grant after release SHALL follow rr_ptr=0.

Structure
REQ-029 A shared package axi_arb_pkg SHALL hold the ARB_MODE encodings (ARB_RR=0, ARB_FIXED=1) and a function computing ID_W.
REQ-030 Grant logic SHALL live in one sub-module rr_arbiter (inputs req, ptr, mode; outputs one-hot grant, grant index, any_grant); the holding register and pointer update stay in axi_aw_arbiter.

Verification
REQ-031 NUM_CH=4, mode 0: all channels valid continuously, m_awready=1 -> m_awid sequence 0,1,2,3,0 on consecutive cycles, no bubble.
REQ-032 Backpressure: ch2 addr 0x0000_1000 accepted, m_awready=0 for 5 cycles -> m_awaddr=0x0000_1000, m_awid=2 stable, all s_awready=0 for those cycles; transfer completes on the cycle m_awready=1.
REQ-033 Mode 1: ch1 and ch3 valid continuously -> ch1 granted every cycle, ch3 never granted while ch1 is valid.
REQ-034 Wrap: rr_ptr=3 (after grant to ch2), only ch0 and ch3 valid -> ch3 granted first, then ch0.
REQ-035 Reset mid-operation: assert rst while m_awvalid=1 -> m_awvalid=0 in the same cycle; after release, all valid -> first m_awid=0.
REQ-036 Idle: no s_awvalid, m_awvalid=0 -> busy=0, all s_awready=0, rr_ptr unchanged over 10 cycles.
